// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Bundles every bus signal of mul_arbiter: the NREQ request channels, the
// multiplier start/fin interface and the tagged response channel.
//
// Modports
//   slave  : the arbiter itself. It serves the requesters, drives the
//            multiplier and produces the response.
//   master : the surrounding system (requesters, multiplier, response sink).
//
// Signals
//   req_valid[NREQ]   request valid per requester
//   req_ready[NREQ]   request accept, one-hot or zero
//   req_a/req_b       packed operands, requester i at [DW*i +: DW]
//   mul_a/mul_b       operands to the multiplier
//   mul_start         one-cycle start pulse
//   mul_fin           multiplier done pulse, mul_o valid with it
//   mul_o             2*DW+1 bit product
//   rsp_valid/ready   response handshake
//   rsp_data          product, 0 on abort
//   rsp_id            id of the requester that issued the job
//   rsp_err           1 = job aborted by the watchdog
//   busy              arbiter is not idle
// ---------------------------------------------------------------------------
interface mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 8
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic               mul_start;
    logic               mul_fin;
    logic [2*DW:0]      mul_o;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*DW:0]      rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_err;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_fin, mul_o, rsp_ready,
        output req_ready, mul_a, mul_b, mul_start, rsp_valid, rsp_data,
               rsp_id, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_fin, mul_o, rsp_ready,
        input  req_ready, mul_a, mul_b, mul_start, rsp_valid, rsp_data,
               rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one sequential DW x DW multiplier between NREQ requesters.
// A round-robin grant is offered in IDLE; the accepted job's operands are
// latched, the multiplier is started with a one-cycle pulse, its fin pulse
// is awaited under a watchdog, and the result (or an error response on
// timeout) is returned on a single valid/ready channel tagged with the id.
//
// Ports
//   ck     clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    mul_arbiter_if.slave, see the interface file for the signal list
//
// Parameters
//   NREQ     number of requesters (2..8)
//   IDW      requester id width, 2**IDW >= NREQ
//   DW       operand width, result width is 2*DW+1
//   TIMEOUT  cycles allowed in WAIT before the job is aborted (>= 2)
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         ck,
    input  logic         rst_n,
    mul_arbiter_if.slave bus
);

    localparam int RW  = 2 * DW + 1;
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   cur_id_r;
    logic [WDW-1:0]   wdog_r;
    logic [DW-1:0]    mul_a_r;
    logic [DW-1:0]    mul_b_r;
    logic             mul_start_r;
    logic             rsp_valid_r;
    logic [RW-1:0]    rsp_data_r;
    logic [IDW-1:0]   rsp_id_r;
    logic             rsp_err_r;
    logic             busy_r;

    logic [2*NREQ-1:0] dbl_valid_s;
    logic [NREQ-1:0]   rot_valid_s;
    logic              grant_vld_s;
    logic [IDW-1:0]    grant_s;
    logic [IDW-1:0]    next_ptr_s;
    logic [NREQ-1:0]   req_ready_s;
    logic              wdog_done_s;
    int                off_v;
    int                sum_v;

    // Round-robin grant: rotate the valid vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then rotate the offset back to an id.
    always_comb begin
        dbl_valid_s = {bus.req_valid, bus.req_valid} >> rr_ptr_r;
        rot_valid_s = dbl_valid_s[NREQ-1:0];
        grant_vld_s = |bus.req_valid;
        off_v       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_valid_s[i]) begin
                off_v = i;
            end else begin
                off_v = off_v;
            end
        end
        sum_v = int'(rr_ptr_r) + off_v;
        if (sum_v >= NREQ) begin
            sum_v = sum_v - NREQ;
        end else begin
            sum_v = sum_v;
        end
        grant_s = IDW'(sum_v);
    end

    // Pointer moves just past the requester that was served last.
    always_comb begin
        if (int'(cur_id_r) >= NREQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = cur_id_r + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    // Accept is offered only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (rst_n && (state_r == IDLE) && grant_vld_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Watchdog reaches its last allowed WAIT cycle.
    always_comb begin
        if (wdog_r == WDW'(TIMEOUT - 1)) begin
            wdog_done_s = 1'b1;
        end else begin
            wdog_done_s = 1'b0;
        end
    end

    // Job sequencer: IDLE -> START -> WAIT -> RESP -> IDLE, outputs registered.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            cur_id_r    <= '0;
            wdog_r      <= '0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            mul_start_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_id_r    <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Any valid request implies the granted bit is ready.
                    if (grant_vld_s) begin
                        mul_a_r     <= bus.req_a[int'(grant_s) * DW +: DW];
                        mul_b_r     <= bus.req_b[int'(grant_s) * DW +: DW];
                        cur_id_r    <= grant_s;
                        mul_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= START;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                START: begin
                    // mul_fin is deliberately not looked at here.
                    mul_start_r <= 1'b0;
                    wdog_r      <= '0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    // fin has priority over a coincident timeout.
                    if (bus.mul_fin) begin
                        rsp_data_r  <= bus.mul_o;
                        rsp_id_r    <= cur_id_r;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (wdog_done_s) begin
                        rsp_data_r  <= '0;
                        rsp_id_r    <= cur_id_r;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        wdog_r      <= wdog_r + {{(WDW-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rr_ptr_r    <= next_ptr_s;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    mul_start_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.mul_start = mul_start_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a behavioural multiplier with programmable fin
// delay, a round-robin/product reference model, directed scenarios and a
// randomized phase.
module tb_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;

    logic ck = 1'b0;
    logic rst_n;

    always #5 ck = ~ck;

    mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) bus ();

    mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ptr      = 0;

    logic [DW-1:0] op_a [NREQ];
    logic [DW-1:0] op_b [NREQ];

    // multiplier model controls
    int fin_delay_cfg  = 8;
    bit stray_on_start = 1'b0;
    int stray_cyc      = -1;
    int cyc            = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Sequential multiplier: fin arrives fin_delay_cfg cycles after the start cycle.
    initial begin
        int cd;
        logic [DW-1:0] la;
        logic [DW-1:0] lb;
        logic fin_v;
        logic [2*DW:0] o_v;
        cd = -1;
        la = '0;
        lb = '0;
        bus.mul_fin = 1'b0;
        bus.mul_o   = '0;
        forever begin
            @(posedge ck);
            #1;
            cyc++;
            fin_v = 1'b0;
            o_v   = 17'h1ABCD;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fin_v = 1'b1;
                    o_v   = 17'(la) * 17'(lb);
                    cd    = -1;
                end
            end
            if (bus.mul_start === 1'b1) begin
                la = bus.mul_a;
                lb = bus.mul_b;
                cd = (fin_delay_cfg > 0) ? fin_delay_cfg : -1;
                if (stray_on_start) fin_v = 1'b1;
            end
            if (cyc == stray_cyc) fin_v = 1'b1;
            bus.mul_fin = fin_v;
            bus.mul_o   = o_v;
        end
    end

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_a[k*DW +: DW] = op_a[k];
            bus.req_b[k*DW +: DW] = op_b[k];
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = DW'($urandom_range(0, 255));
            op_b[k] = DW'($urandom_range(0, 255));
        end
    endtask

    // Called at a negedge with the arbiter idle; returns at the negedge of the START cycle.
    task automatic start_job(input logic [NREQ-1:0] v, input int d, input int exp_g,
                             input bit scramble, output int g);
        fin_delay_cfg = d;
        g = (exp_g >= 0) ? exp_g : rr_pick(v, ptr);
        drive_ops();
        bus.req_valid = v;
        #1;
        check("req_ready_grant", 32'(bus.req_ready), 32'd1 << g);
        @(negedge ck);
        check("mul_start_high", 32'(bus.mul_start), 32'd1);
        check("mul_a_latched", 32'(bus.mul_a), 32'(op_a[g]));
        check("mul_b_latched", 32'(bus.mul_b), 32'(op_b[g]));
        check("busy_start", 32'(bus.busy), 32'd1);
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (scramble) bus.req_valid = NREQ'($urandom_range(0, 15));
    endtask

    // Waits for the response, applies bp cycles of backpressure, completes the handshake.
    task automatic finish_job(input int g, input int d, input int bp);
        int lat;
        bit got;
        bit exp_err;
        int exp_lat;
        logic [2*DW:0] exp_d;
        exp_err = (d < 1) || (d > TIMEOUT);
        exp_lat = exp_err ? TIMEOUT + 1 : d + 1;
        exp_d   = exp_err ? 17'd0 : 17'(op_a[g]) * 17'(op_b[g]);
        bus.rsp_ready = (bp == 0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge ck);
            lat++;
            check("mul_start_low", 32'(bus.mul_start), 32'd0);
            if (bus.rsp_valid === 1'b1) got = 1'b1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
        check("rsp_id", 32'(bus.rsp_id), 32'(g));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("mul_a_stable", 32'(bus.mul_a), 32'(op_a[g]));
        for (int i = 0; i < bp; i++) begin
            @(negedge ck);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data", 32'(bus.rsp_data), 32'(exp_d));
            check("hold_id", 32'(bus.rsp_id), 32'(g));
            check("hold_busy", 32'(bus.busy), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            if (i == bp - 1) bus.rsp_ready = 1'b1;
        end
        @(negedge ck);
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        ptr = (g + 1) % NREQ;
    endtask

    // Asserts reset at a negedge, checks reset values, releases three cycles later.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check("rst_mul_a", 32'(bus.mul_a), 32'd0);
        check("rst_mul_b", 32'(bus.mul_b), 32'd0);
        check("rst_mul_start", 32'(bus.mul_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'h0;
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
        ptr = 0;
    endtask

    initial begin
        int g;
        int bad;
        int d;
        int order [6];
        order = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        #2;
        do_reset();
        @(negedge ck);

        // single request, 0x0F * 0x11
        op_a[0] = 8'h0F;
        op_b[0] = 8'h11;
        start_job(4'b0001, 8, 0, 1'b0, g);
        bus.req_valid = 4'b0000;
        finish_job(g, 8, 0);

        // all requesters valid: fixed order after reset
        do_reset();
        @(negedge ck);
        rand_ops();
        op_a[2] = 8'hFF;
        op_b[2] = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(1, 10));
            start_job(4'hF, d, order[i], 1'b0, g);
            finish_job(g, d, 0);
        end

        // backpressure with everybody requesting
        rand_ops();
        start_job(4'hF, 5, -1, 1'b0, g);
        finish_job(g, 5, 10);

        // timeout, boundary cases, recovery
        rand_ops();
        start_job(4'b0100, -1, -1, 1'b0, g);
        finish_job(g, -1, 0);
        start_job(4'b0100, TIMEOUT, -1, 1'b0, g);
        finish_job(g, TIMEOUT, 0);
        start_job(4'b0010, TIMEOUT + 1, -1, 1'b0, g);
        finish_job(g, TIMEOUT + 1, 3);
        start_job(4'b0100, 1, -1, 1'b0, g);
        finish_job(g, 1, 0);

        // reset in WAIT, late fin must not produce a response
        rand_ops();
        start_job(4'b1000, 12, -1, 1'b0, g);
        repeat (4) @(negedge ck);
        check("wait_busy", 32'(bus.busy), 32'd1);
        do_reset();
        bad = 0;
        repeat (10) begin
            @(negedge ck);
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        check("late_fin_ignored", 32'(bad), 32'd0);
        start_job(4'hF, 4, 0, 1'b0, g);
        finish_job(g, 4, 0);

        // stray fin in IDLE and in the start cycle
        bus.req_valid = '0;
        stray_cyc = cyc + 1;
        bad = 0;
        repeat (4) begin
            @(negedge ck);
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        check("stray_idle_ignored", 32'(bad), 32'd0);
        stray_on_start = 1'b1;
        rand_ops();
        start_job(4'b1000, 6, -1, 1'b0, g);
        stray_on_start = 1'b0;
        finish_job(g, 6, 0);

        // randomized traffic
        for (int t = 0; t < 25; t++) begin
            logic [NREQ-1:0] v;
            int r;
            rand_ops();
            v = NREQ'($urandom_range(1, 15));
            r = int'($urandom_range(0, 9));
            d = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT + 1 : int'($urandom_range(1, 20));
            start_job(v, d, -1, 1'b1, g);
            finish_job(g, d, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end
endmodule
